// File: rtl/jk_pkg.sv
// Shared types and constants for the JK flip-flop sequence driver.
package jk_pkg;

  // Driver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } jk_state_e;

  // Value placed on an excitation input whose level does not matter.
  localparam logic JK_DC = 1'b0;

endpackage : jk_pkg

// File: rtl/jk_excite.sv
// JK excitation table: the j/k needed to move a JK flip-flop from q to q_next.
module jk_excite
  import jk_pkg::*;
#(
  parameter logic DC = JK_DC
) (
  input  logic q,
  input  logic q_next,
  output logic j,
  output logic k
);

  // Set from 0 needs only J; clear from 1 needs only K; the other input is free.
  always_comb begin
    j = DC;
    k = DC;
    if (q) begin
      j = DC;
      k = ~q_next;
    end else begin
      j = q_next;
      k = DC;
    end
  end

endmodule : jk_excite

// File: rtl/jk_seq_driver.sv
// Drives a target bit sequence into an external JK flip-flop and checks q feedback.
module jk_seq_driver
  import jk_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter logic        DC_VAL = JK_DC,
  localparam int unsigned LEN_W = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  output logic              j,
  output logic              k,
  input  logic              q_fb,
  output logic              busy,
  output logic              done,
  output logic [7:0]        mismatch_cnt,
  output logic              err
);

  jk_state_e         state_q, state_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              expq_q, expq_d;
  logic              cur_vld_q, cur_vld_d;
  logic              cur_bit_q, cur_bit_d;
  logic              chk_vld_q, chk_vld_d;
  logic              chk_bit_q, chk_bit_d;
  logic              j_d, k_d, ready_d, busy_d, done_d, err_d;
  logic [7:0]        cnt_d;

  logic              ex_q, ex_t, ex_j, ex_k;
  logic [LEN_W-1:0]  len_clamp;
  logic              accept, bit_err;

  // On accept the first bit is excited from live q_fb; afterwards from the tracked state.
  assign ex_q      = (state_q == ST_IDLE) ? q_fb : expq_q;
  assign ex_t      = (state_q == ST_IDLE) ? in_data[0] : sh_q[0];
  assign len_clamp = (in_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : in_len;
  assign accept    = (state_q == ST_IDLE) && in_ready && in_valid;
  assign bit_err   = chk_vld_q && (q_fb != chk_bit_q);

  jk_excite #(.DC(DC_VAL)) u_excite (
    .q      (ex_q),
    .q_next (ex_t),
    .j      (ex_j),
    .k      (ex_k)
  );

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    len_d     = len_q;
    idx_d     = idx_q;
    expq_d    = expq_q;
    j_d       = 1'b0;
    k_d       = 1'b0;
    cur_vld_d = 1'b0;
    cur_bit_d = cur_bit_q;
    chk_vld_d = cur_vld_q;
    chk_bit_d = cur_bit_q;
    err_d     = err | bit_err;
    cnt_d     = (bit_err && (mismatch_cnt != 8'hFF)) ? mismatch_cnt + 8'd1 : mismatch_cnt;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d  = 8'd0;
          err_d  = 1'b0;
          len_d  = len_clamp;
          expq_d = q_fb;
          if (len_clamp == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_DRIVE;
            j_d       = ex_j;
            k_d       = ex_k;
            cur_vld_d = 1'b1;
            cur_bit_d = in_data[0];
            expq_d    = in_data[0];
            sh_d      = in_data >> 1;
            idx_d     = LEN_W'(1);
          end
        end
      end
      ST_DRIVE: begin
        if (idx_q == len_q) begin
          state_d = ST_CHECK;
        end else begin
          j_d       = ex_j;
          k_d       = ex_k;
          cur_vld_d = 1'b1;
          cur_bit_d = sh_q[0];
          expq_d    = sh_q[0];
          sh_d      = sh_q >> 1;
          idx_d     = idx_q + LEN_W'(1);
        end
      end
      ST_CHECK: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
    done_d  = (state_d == ST_DONE);
  end

  // State and registered outputs; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      expq_q       <= 1'b0;
      cur_vld_q    <= 1'b0;
      cur_bit_q    <= 1'b0;
      chk_vld_q    <= 1'b0;
      chk_bit_q    <= 1'b0;
      j            <= 1'b0;
      k            <= 1'b0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mismatch_cnt <= 8'd0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      expq_q       <= expq_d;
      cur_vld_q    <= cur_vld_d;
      cur_bit_q    <= cur_bit_d;
      chk_vld_q    <= chk_vld_d;
      chk_bit_q    <= chk_bit_d;
      j            <= j_d;
      k            <= k_d;
      in_ready     <= ready_d;
      busy         <= busy_d;
      done         <= done_d;
      mismatch_cnt <= cnt_d;
      err          <= err_d;
    end
  end

endmodule : jk_seq_driver

// File: doc/jk_seq_driver.md
JK_SEQ_DRIVER -- requirements
Module: jk_seq_driver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, the maximum sequence length in bits.
REQ-002 SHALL have parameter DC_VAL, default 0, the value driven on an excitation don't-care input (J or K).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: job request.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a job.
REQ-007 SHALL have port in_data, input, DATA_W bits: target q sequence, LSB first.
REQ-008 SHALL have port in_len, input, $clog2(DATA_W)+1 bits: number of bits to drive.
REQ-009 SHALL have port j, output, 1 bit: registered J drive to the external JK flip-flop.
REQ-010 SHALL have port k, output, 1 bit: registered K drive to the external JK flip-flop.
REQ-011 SHALL have port q_fb, input, 1 bit: q fed back from the external flip-flop.
REQ-012 SHALL have port busy, output, 1 bit: a job is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle job-complete pulse.
REQ-014 SHALL have port mismatch_cnt, output, 8 bits: count of failed bit checks.
REQ-015 SHALL have port err, output, 1 bit: sticky flag set by any mismatch.

Function
REQ-016 SHALL be a four-state FSM: IDLE, DRIVE, CHECK, DONE.
REQ-017 SHALL accept a job on in_valid && in_ready in IDLE, latching in_data and in_len, sampling q_fb as expected state exp_q, and clearing mismatch_cnt and err.
REQ-018 SHALL clamp in_len > DATA_W to DATA_W.
REQ-019 SHALL go IDLE->DONE when in_len == 0, and IDLE->DRIVE otherwise.
REQ-020 SHALL present bit i (i = 0..len-1) on j/k during DRIVE cycle i+1 after the accept edge.
REQ-021 SHALL derive j/k from exp_q and target bit t: 0->0 gives j=0, k=DC_VAL; 0->1 gives j=1, k=DC_VAL; 1->0 gives j=DC_VAL, k=1; 1->1 gives j=DC_VAL, k=0.
REQ-022 SHALL set exp_q to t after each presented bit.
REQ-023 SHALL compare q_fb against bit i one cycle after bit i is presented.
REQ-024 SHALL, on a mismatch, increment mismatch_cnt (saturating at 255) and set err.
REQ-025 SHALL go DRIVE->CHECK after the last bit, spend 1 cycle in CHECK comparing the last bit, then enter DONE.
REQ-026 SHALL hold DONE for 1 cycle with done=1, then return to IDLE.
REQ-027 SHALL drive j=k=0 (hold) in IDLE, CHECK and DONE.
REQ-028 SHALL drive in_ready=1 only in IDLE, registered, and ignore in_valid at all other times.
REQ-029 SHALL drive busy=1 in DRIVE and CHECK.
REQ-030 SHALL hold mismatch_cnt and err stable until the next accept.

Reset
REQ-031 SHALL, while rst_n=0, asynchronously force state IDLE, j=k=0, in_ready=0, busy=0, done=0, mismatch_cnt=0, err=0.
REQ-032 SHALL drive in_ready=1 on the first clock edge after rst_n deasserts.
REQ-033 SHALL abort any in-flight job on reset, with no done pulse for that job.

Structure
REQ-034 SHALL place the FSM state enum and the excitation don't-care constant in shared package jk_pkg.
REQ-035 SHALL implement the excitation lookup in combinational sub-module jk_excite (inputs q, q_next; outputs j, k).

Verification
REQ-036 SHALL cover reset: rst_n=0 -> j=k=0, busy=0, in_ready=0; release -> in_ready=1 after one edge.
REQ-037 SHALL cover a normal job against a JKFF model with q=0, in_data=8'hA6, in_len=8 -> j/k matches the REQ-021 table, mismatch_cnt=0, done high in cycle 10 after accept.
REQ-038 SHALL cover a stuck-at fault: q_fb forced to 0, in_data=8'hFF, in_len=8 -> mismatch_cnt=8, err=1.
REQ-039 SHALL cover boundaries: in_len=0 -> done in cycle 1 with no j/k activity; in_len=12 -> exactly 8 bits driven.
REQ-040 SHALL cover reset mid-job at cycle 4 -> j=k=0 immediately, busy=0, no done pulse.
REQ-041 SHALL cover in_valid held high during DRIVE -> no second accept until after DONE.
